// File: rtl/deskew_lane_ctrl.sv
// ============================================================================
// Module   : deskew_lane_ctrl
// Purpose  : Multi-lane PCS deskew controller. It times AM arrivals, loads
//            per-lane FIFO delays, confirms alignment and declares lock.
// Optional : DESKEW_SKEW_MONITOR_EN adds the max-skew and fail-count monitors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module deskew_lane_ctrl #(
    parameter int N_LANES      = 20,
    parameter int MAX_SKEW     = 16,
    parameter int NB_DELAY     = $clog2(MAX_SKEW) + 1,
    parameter int N_LOCK_CHECK = 2,
    parameter int N_UNLOCK     = 3
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_valid,
    input  logic                         i_resync,
    input  logic [N_LANES-1:0]           i_start_of_lane,
    input  logic [N_LANES-1:0]           i_aligned_am,
    output logic [N_LANES*NB_DELAY-1:0]  o_lane_delay,
    output logic                         o_set_fifo_delay,
    output logic                         o_write_fifo_enb,
    output logic                         o_read_fifo_enb,
    output logic                         o_deskew_done,
    output logic                         o_invalid_skew,
    output logic [NB_DELAY-1:0]          o_max_skew,
    output logic [7:0]                   o_fail_count
);

    localparam int                   c_NB_GOOD     = $clog2(N_LOCK_CHECK + 1);
    localparam int                   c_NB_BAD      = $clog2(N_UNLOCK + 1);
    localparam logic [NB_DELAY-1:0]  c_MAX_SKEW    = NB_DELAY'(MAX_SKEW);
    localparam logic [c_NB_GOOD-1:0] c_LOCK_TARGET = c_NB_GOOD'(N_LOCK_CHECK);
    localparam logic [c_NB_BAD-1:0]  c_UNLOCK_TGT  = c_NB_BAD'(N_UNLOCK);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_COUNT  = 3'd1,
        S_CALC   = 3'd2,
        S_CHECK  = 3'd3,
        S_LOCKED = 3'd4
    } state_t;

    state_t                      r_state;
    logic [NB_DELAY-1:0]         r_counter;
    logic [N_LANES-1:0]          r_seen;
    logic [NB_DELAY-1:0]         r_arrival [N_LANES];
    logic [N_LANES*NB_DELAY-1:0] r_lane_delay;
    logic [c_NB_GOOD-1:0]        r_good_cnt;
    logic [c_NB_BAD-1:0]         r_bad_cnt;
    logic                        r_set_fifo_delay;
    logic                        r_write_fifo_enb;
    logic                        r_read_fifo_enb;
    logic                        r_deskew_done;
    logic                        r_invalid_skew;

    logic                        w_qual;
    logic [N_LANES-1:0]          w_seen_next;
    logic                        w_am_full;
    logic                        w_am_any;
    logic [NB_DELAY-1:0]         w_max_arrival;

    assign w_qual      = i_enable & i_valid;
    assign w_seen_next = r_seen | i_start_of_lane;
    assign w_am_full   = &i_aligned_am;
    assign w_am_any    = |i_aligned_am;

    always_comb begin
        w_max_arrival = '0;
        for (int j = 0; j < N_LANES; j++) begin
            if (r_arrival[j] > w_max_arrival) begin
                w_max_arrival = r_arrival[j];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_resync) begin
            r_state          <= S_INIT;
            r_counter        <= '0;
            r_seen           <= '0;
            r_lane_delay     <= '0;
            r_good_cnt       <= '0;
            r_bad_cnt        <= '0;
            r_set_fifo_delay <= 1'b0;
            r_write_fifo_enb <= 1'b0;
            r_read_fifo_enb  <= 1'b0;
            r_deskew_done    <= 1'b0;
            r_invalid_skew   <= 1'b0;
            for (int j = 0; j < N_LANES; j++) begin
                r_arrival[j] <= '0;
            end
        end else begin
            r_set_fifo_delay <= 1'b0;
            r_invalid_skew   <= 1'b0;
            if (w_qual) begin
                case (r_state)
                    S_INIT: begin
                        if (|i_start_of_lane) begin
                            for (int j = 0; j < N_LANES; j++) begin
                                if (i_start_of_lane[j]) r_arrival[j] <= '0;
                            end
                            r_seen           <= i_start_of_lane;
                            r_counter        <= NB_DELAY'(1);
                            r_write_fifo_enb <= 1'b1;
                            r_state          <= S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        for (int j = 0; j < N_LANES; j++) begin
                            if (i_start_of_lane[j] && !r_seen[j]) r_arrival[j] <= r_counter;
                        end
                        r_seen    <= w_seen_next;
                        r_counter <= r_counter + NB_DELAY'(1);
                        // Completing the mask wins over an overflow in the same cycle.
                        if (&w_seen_next) begin
                            r_state <= S_CALC;
                        end else if (r_counter == c_MAX_SKEW) begin
                            r_invalid_skew   <= 1'b1;
                            r_seen           <= '0;
                            r_counter        <= '0;
                            r_write_fifo_enb <= 1'b0;
                            r_state          <= S_INIT;
                        end
                    end
                    S_CALC: begin
                        for (int j = 0; j < N_LANES; j++) begin
                            r_lane_delay[j*NB_DELAY +: NB_DELAY] <= w_max_arrival - r_arrival[j];
                        end
                        r_set_fifo_delay <= 1'b1;
                        r_read_fifo_enb  <= 1'b1;
                        r_good_cnt       <= '0;
                        r_state          <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (w_am_full) begin
                            r_good_cnt <= r_good_cnt + c_NB_GOOD'(1);
                            if (r_good_cnt + c_NB_GOOD'(1) == c_LOCK_TARGET) begin
                                r_bad_cnt     <= '0;
                                r_deskew_done <= 1'b1;
                                r_state       <= S_LOCKED;
                            end
                        end else if (w_am_any) begin
                            r_invalid_skew   <= 1'b1;
                            r_seen           <= '0;
                            r_counter        <= '0;
                            r_write_fifo_enb <= 1'b0;
                            r_read_fifo_enb  <= 1'b0;
                            r_state          <= S_INIT;
                        end
                    end
                    S_LOCKED: begin
                        if (w_am_full) begin
                            r_bad_cnt <= '0;
                        end else if (w_am_any) begin
                            r_bad_cnt <= r_bad_cnt + c_NB_BAD'(1);
                            if (r_bad_cnt + c_NB_BAD'(1) == c_UNLOCK_TGT) begin
                                r_invalid_skew   <= 1'b1;
                                r_deskew_done    <= 1'b0;
                                r_seen           <= '0;
                                r_counter        <= '0;
                                r_write_fifo_enb <= 1'b0;
                                r_read_fifo_enb  <= 1'b0;
                                r_state          <= S_INIT;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_INIT;
                    end
                endcase
            end
        end
    end

    assign o_lane_delay     = r_lane_delay;
    assign o_set_fifo_delay = r_set_fifo_delay;
    assign o_write_fifo_enb = r_write_fifo_enb;
    assign o_read_fifo_enb  = r_read_fifo_enb;
    assign o_deskew_done    = r_deskew_done;
    assign o_invalid_skew   = r_invalid_skew;

`ifdef DESKEW_SKEW_MONITOR_EN
    logic [NB_DELAY-1:0] r_max_skew;
    logic [7:0]          r_fail_count;

    // Survives resync so the history spans repeated deskew attempts.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_max_skew   <= '0;
            r_fail_count <= '0;
        end else begin
            if (w_qual && !i_resync && r_state == S_CALC) begin
                r_max_skew <= w_max_arrival;
            end
            if (r_invalid_skew && r_fail_count != 8'hFF) begin
                r_fail_count <= r_fail_count + 8'd1;
            end
        end
    end

    assign o_max_skew   = r_max_skew;
    assign o_fail_count = r_fail_count;
`else
    assign o_max_skew   = '0;
    assign o_fail_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_deskew_lane_ctrl.sv
// ============================================================================
// Module   : tb_deskew_lane_ctrl
// Purpose  : Directed bench for deskew_lane_ctrl with four lanes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deskew_lane_ctrl;

    localparam int N_LANES  = 4;
    localparam int MAX_SKEW = 16;
    localparam int NB_DELAY = 5;

    logic                        i_clock = 1'b0;
    logic                        i_reset = 1'b1;
    logic                        i_enable = 1'b0;
    logic                        i_valid = 1'b0;
    logic                        i_resync = 1'b0;
    logic [N_LANES-1:0]          i_start_of_lane = '0;
    logic [N_LANES-1:0]          i_aligned_am = '0;
    logic [N_LANES*NB_DELAY-1:0] o_lane_delay;
    logic                        o_set_fifo_delay;
    logic                        o_write_fifo_enb;
    logic                        o_read_fifo_enb;
    logic                        o_deskew_done;
    logic                        o_invalid_skew;
    logic [NB_DELAY-1:0]         o_max_skew;
    logic [7:0]                  o_fail_count;

    int n_vec  = 0;
    int n_fail = 0;

    deskew_lane_ctrl #(
        .N_LANES     (N_LANES),
        .MAX_SKEW    (MAX_SKEW),
        .NB_DELAY    (NB_DELAY),
        .N_LOCK_CHECK(2),
        .N_UNLOCK    (3)
    ) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_enable        (i_enable),
        .i_valid         (i_valid),
        .i_resync        (i_resync),
        .i_start_of_lane (i_start_of_lane),
        .i_aligned_am    (i_aligned_am),
        .o_lane_delay    (o_lane_delay),
        .o_set_fifo_delay(o_set_fifo_delay),
        .o_write_fifo_enb(o_write_fifo_enb),
        .o_read_fifo_enb (o_read_fifo_enb),
        .o_deskew_done   (o_deskew_done),
        .o_invalid_skew  (o_invalid_skew),
        .o_max_skew      (o_max_skew),
        .o_fail_count    (o_fail_count)
    );

    always #5 i_clock = ~i_clock;

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_delay", 32'(o_lane_delay), 32'h0);
        check("rst_done", 32'(o_deskew_done), 32'h0);
        check("rst_wr", 32'(o_write_fifo_enb), 32'h0);
        check("rst_rd", 32'(o_read_fifo_enb), 32'h0);
        check("rst_inv", 32'(o_invalid_skew), 32'h0);
        check("rst_set", 32'(o_set_fifo_delay), 32'h0);
        i_reset  = 1'b0;
        i_enable = 1'b1;
        i_valid  = 1'b1;

        // Overflow: lane 2 never arrives
        i_start_of_lane = 4'b1011;
        tick();
        check("ovf_wr_count", 32'(o_write_fifo_enb), 32'h1);
        i_start_of_lane = 4'b0000;
        repeat (15) tick();
        check("ovf_no_early", 32'(o_invalid_skew), 32'h0);
        tick();
        check("ovf_pulse", 32'(o_invalid_skew), 32'h1);
        check("ovf_wr_init", 32'(o_write_fifo_enb), 32'h0);
        check("ovf_done", 32'(o_deskew_done), 32'h0);
        tick();
        check("ovf_one_cycle", 32'(o_invalid_skew), 32'h0);

        // Second overflow
        i_start_of_lane = 4'b1011;
        tick();
        i_start_of_lane = 4'b0000;
        repeat (16) tick();
        check("ovf2_pulse", 32'(o_invalid_skew), 32'h1);
        tick();

        // Arrivals 0,2,5,3 with a 5-cycle qualification gap
        i_start_of_lane = 4'b0001;
        tick();
        i_start_of_lane = 4'b0000;
        tick();
        i_start_of_lane = 4'b0010;
        tick();
        i_start_of_lane = 4'b1000;
        tick();
        i_valid = 1'b0;
        i_start_of_lane = 4'b0100;
        repeat (5) tick();
        check("gap_wr", 32'(o_write_fifo_enb), 32'h1);
        check("gap_set", 32'(o_set_fifo_delay), 32'h0);
        i_valid = 1'b1;
        i_start_of_lane = 4'b0001;
        tick();
        i_start_of_lane = 4'b0100;
        tick();
        check("pre_calc_set", 32'(o_set_fifo_delay), 32'h0);
        check("pre_calc_delay", 32'(o_lane_delay), 32'h0);
        i_start_of_lane = 4'b0000;
        tick();
        check("calc_set", 32'(o_set_fifo_delay), 32'h1);
        check("calc_delay", 32'(o_lane_delay), 32'({5'd2, 5'd0, 5'd3, 5'd5}));
        check("check_wr", 32'(o_write_fifo_enb), 32'h1);
        check("check_rd", 32'(o_read_fifo_enb), 32'h1);
`ifdef DESKEW_SKEW_MONITOR_EN
        check("mon_fail2", 32'(o_fail_count), 32'd2);
        check("mon_max5", 32'(o_max_skew), 32'd5);
`else
        check("mon_off_fail", 32'(o_fail_count), 32'd0);
        check("mon_off_max", 32'(o_max_skew), 32'd0);
`endif
        tick();
        check("set_one_cycle", 32'(o_set_fifo_delay), 32'h0);

        // Lock on two full AM periods
        i_aligned_am = 4'hF;
        tick();
        check("lock_first", 32'(o_deskew_done), 32'h0);
        i_aligned_am = 4'h0;
        tick();
        i_aligned_am = 4'hF;
        tick();
        check("lock_second", 32'(o_deskew_done), 32'h1);

        // Two partials then a full keep lock
        i_aligned_am = 4'hB;
        tick();
        tick();
        i_aligned_am = 4'hF;
        tick();
        check("keep_done", 32'(o_deskew_done), 32'h1);
        check("keep_inv", 32'(o_invalid_skew), 32'h0);

        // Three partials unlock
        i_aligned_am = 4'hB;
        tick();
        tick();
        check("unlock_pre", 32'(o_deskew_done), 32'h1);
        tick();
        check("unlock_inv", 32'(o_invalid_skew), 32'h1);
        check("unlock_done", 32'(o_deskew_done), 32'h0);
        check("unlock_rd", 32'(o_read_fifo_enb), 32'h0);
        check("hold_delay", 32'(o_lane_delay), 32'({5'd2, 5'd0, 5'd3, 5'd5}));
        i_aligned_am = 4'h0;
        tick();
        check("unlock_one_cycle", 32'(o_invalid_skew), 32'h0);

        // Resync clears the datapath but not the monitor
        i_resync = 1'b1;
        tick();
        i_resync = 1'b0;
        check("resync_delay", 32'(o_lane_delay), 32'h0);
`ifdef DESKEW_SKEW_MONITOR_EN
        check("resync_fail", 32'(o_fail_count), 32'd3);
        check("resync_max", 32'(o_max_skew), 32'd5);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("reset_fail", 32'(o_fail_count), 32'd0);
        check("reset_max", 32'(o_max_skew), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/deskew_lane_ctrl.md
Name: deskew_lane_ctrl

Overview:
- Parametrised multi-lane deskew controller for the PCS receive path, between the per-lane alignment-marker lock and the per-lane programmable-delay FIFOs.
- Measures each lane's alignment-marker (AM) arrival time with an internal common counter, then computes and publishes a per-lane FIFO delay.
- Confirms alignment on later AM periods and declares deskew lock.
- Re-arms itself after repeated misaligned AM periods.

Parameters:
- N_LANES, 20, number of PCS lanes.
- MAX_SKEW, 16, maximum tolerated skew in qualified cycles. Must satisfy MAX_SKEW <= 2^NB_DELAY-1.
- NB_DELAY, $clog2(MAX_SKEW)+1, width of the arrival counter and of each lane delay.
- N_LOCK_CHECK, 2, consecutive fully aligned AM periods required to declare lock.
- N_UNLOCK, 3, consecutive misaligned AM periods in LOCKED that force re-deskew.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  block enable.
- i_valid  in  1  qualifies the current cycle.
- i_resync  in  1  synchronous restart; same effect as reset.
- i_start_of_lane  in  N_LANES  per-lane AM-seen pulse, taken before the FIFOs.
- i_aligned_am  in  N_LANES  per-lane AM pulse, taken at the FIFO outputs.
- o_lane_delay  out  N_LANES*NB_DELAY  flattened per-lane delay; lane j occupies bits [j*NB_DELAY +: NB_DELAY].
- o_set_fifo_delay  out  1  one-cycle pulse telling the FIFOs to load o_lane_delay.
- o_write_fifo_enb  out  1  FIFO write enable.
- o_read_fifo_enb  out  1  FIFO read enable.
- o_deskew_done  out  1  lock indication.
- o_invalid_skew  out  1  one-cycle pulse on skew overflow or on an unlock event.
- o_max_skew  out  NB_DELAY  largest measured skew (optional feature).
- o_fail_count  out  8  failure counter (optional feature).

Behaviour:
- Clocking and reset:
  - One clock.
  - i_reset or i_resync high forces, on the next edge: state=INIT, counter=0, seen mask=0, all delays=0, lock/unlock counters=0, o_deskew_done=0.
  - All registered outputs reset to 0.
  - Reset has priority over every other event.
- Qualification and freeze:
  - All state updates occur only when i_enable && i_valid.
  - Otherwise every register holds and all pulse outputs are 0.
- INIT:
  - Outputs idle.
  - Any bit of i_start_of_lane set: those lanes get arrival=0 and are marked seen; counter=1; go to COUNT.
- COUNT:
  - o_write_fifo_enb=1.
  - Each not-yet-seen lane with i_start_of_lane set captures arrival=counter and is marked seen.
  - Repeat pulses on lanes already seen are ignored.
  - Counter increments each qualified cycle.
  - If the seen mask, including lanes captured this cycle, is all ones: go to CALC. This takes priority over the overflow check in the same cycle.
  - Else if counter == MAX_SKEW: o_invalid_skew pulse, return to INIT, clear the mask.
- CALC (one qualified cycle):
  - delay_j = max_arrival - arrival_j, unsigned, never negative.
  - max_arrival is the highest captured arrival.
  - Registered delays become visible on o_lane_delay at CALC exit.
  - o_set_fifo_delay pulses on the same cycle.
  - Go to CHECK with the good-period count at 0.
- CHECK:
  - Write and read enables both 1.
  - i_aligned_am all ones: good count+1. Reaching N_LOCK_CHECK goes to LOCKED.
  - i_aligned_am nonzero but not all ones: o_invalid_skew pulse, go to INIT.
  - All-zero cycles: no action.
- LOCKED:
  - Write and read enables both 1; o_deskew_done=1, registered.
  - Partial AM vector: mismatch count+1.
  - Full AM vector: mismatch count cleared.
  - Mismatch count reaching N_UNLOCK: o_invalid_skew pulse, o_deskew_done deasserts on the next edge, go to INIT.
- Delay hold: o_lane_delay holds its value from CALC until the next CALC or reset.

Optional Feature:
- Macro: DESKEW_SKEW_MONITOR_EN.
- When defined:
  - o_max_skew registers max_arrival at each CALC.
  - o_fail_count is an 8-bit saturating counter (stops at 255) that increments on each o_invalid_skew pulse.
  - Both clear on i_reset only; i_resync does not clear them.
- When undefined: both ports are driven constant 0 and no monitor logic is built.

Test Plan:
- N_LANES=4, start_of_lane pulses at counter 0,2,5,3 for lanes 0..3 -> CALC; o_lane_delay = {2,0,3,5} for lanes {3,2,1,0}; single o_set_fifo_delay pulse.
- Lane 2 never pulses, MAX_SKEW=16 -> o_invalid_skew pulses when counter hits 16; state returns to INIT; o_deskew_done stays 0.
- After CALC, two full i_aligned_am=4'hF periods -> o_deskew_done=1 on the edge after the second one.
- In LOCKED: three consecutive i_aligned_am=4'hB periods -> o_invalid_skew pulse, o_deskew_done=0. Two partials followed by a full -> lock retained.
- i_valid low for 5 cycles during COUNT -> counter and mask frozen; resulting delays equal those of the same sequence with no gaps.
- Macro defined: two overflow failures then a successful CALC with max arrival 5 -> o_fail_count=2, o_max_skew=5; i_resync leaves both unchanged.
